// File: rtl/nand_xor_pkg.sv
// Shared definitions for the time-multiplexed NAND-based XOR scheduler.
//   state_t : FSM encoding. IDLE, then five NAND steps S1..S5, then DONE.
//   REQ0/1  : requester identifiers, used for owner and last-grant tracking.
package nand_xor_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/nand_cell.sv
// W-bit two-input NAND cell, purely combinational. It is the only NAND
// operator in the scheduler and is reused on every step of the XOR network.
//   p, q : operands
//   y    : ~(p & q)
module nand_cell #(
  parameter int W = 8
) (
  input  logic [W-1:0] p,
  input  logic [W-1:0] q,
  output logic [W-1:0] y
);

  assign y = ~(p & q);

endmodule

// File: rtl/nand_xor_sched.sv
// Time-multiplexed W-bit XOR built from one shared NAND cell. The five-NAND
// XOR network is evaluated over states S1..S5; two requesters share the unit
// through a round-robin arbiter with a req/ack handshake.
//   clk, rst          : clock, synchronous active-high reset
//   req0, a0, b0      : requester 0 request level and operands
//   req1, a1, b1      : requester 1 request level and operands
//   ack0, ack1        : one-cycle pulse, operands captured (coincides with S1)
//   done0, done1      : one-cycle pulse, y valid (coincides with DONE)
//   y                 : result, zero outside DONE
//   busy              : high in every state except IDLE
module nand_xor_sched
  import nand_xor_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] y,
  output logic         busy
);

  state_t       state;
  logic [W-1:0] ra, rb, rna, rnb, rt1, rt2, ry;
  logic         owner;
  logic         last;
  logic         ack0_reg, ack1_reg, done0_reg, done1_reg;
  logic [W-1:0] y_reg;

  logic [W-1:0] cell_p, cell_q, cell_y;
  logic         grant_valid;
  logic         grant_id;

  // Input mux of the shared NAND cell; each state selects the operand pair
  // of its step in the XOR network. IDLE/DONE park it on ra,ra.
  always_comb begin
    cell_p = ra;
    cell_q = ra;
    case (state)
      S1: begin cell_p = ra;  cell_q = ra;  end
      S2: begin cell_p = rna; cell_q = rb;  end
      S3: begin cell_p = rb;  cell_q = rb;  end
      S4: begin cell_p = rnb; cell_q = ra;  end
      S5: begin cell_p = rt1; cell_q = rt2; end
      default: begin cell_p = ra; cell_q = ra; end
    endcase
  end

  nand_cell #(.W(W)) u_cell (
    .p(cell_p),
    .q(cell_q),
    .y(cell_y)
  );

  // Round-robin: a tie goes to the requester that was not granted last.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) grant_id = ~last;
    else if (req1)    grant_id = REQ1;
    else              grant_id = REQ0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ra        <= '0;
      rb        <= '0;
      rna       <= '0;
      rnb       <= '0;
      rt1       <= '0;
      rt2       <= '0;
      ry        <= '0;
      owner     <= REQ0;
      last      <= REQ1;   // requester 0 wins the first tie
      ack0_reg  <= 1'b0;
      ack1_reg  <= 1'b0;
      done0_reg <= 1'b0;
      done1_reg <= 1'b0;
      y_reg     <= '0;
    end else begin
      // Pulses and y default low; set only on their single qualifying edge.
      ack0_reg  <= 1'b0;
      ack1_reg  <= 1'b0;
      done0_reg <= 1'b0;
      done1_reg <= 1'b0;
      y_reg     <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            ra       <= (grant_id == REQ1) ? a1 : a0;
            rb       <= (grant_id == REQ1) ? b1 : b0;
            owner    <= grant_id;
            last     <= grant_id;
            ack0_reg <= (grant_id == REQ0);
            ack1_reg <= (grant_id == REQ1);
            state    <= S1;
          end
        end
        S1: begin rna <= cell_y; state <= S2; end
        S2: begin rt1 <= cell_y; state <= S3; end
        S3: begin rnb <= cell_y; state <= S4; end
        S4: begin rt2 <= cell_y; state <= S5; end
        S5: begin
          // The final NAND lands in ry and in the output register together,
          // so y is valid exactly in the DONE cycle.
          ry        <= cell_y;
          y_reg     <= cell_y;
          done0_reg <= (owner == REQ0);
          done1_reg <= (owner == REQ1);
          state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ack0  = ack0_reg;
  assign ack1  = ack1_reg;
  assign done0 = done0_reg;
  assign done1 = done1_reg;
  assign y     = y_reg;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_nand_xor_sched.sv
module tb_nand_xor_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // W=8 instance
  logic       rst;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic       ack0, ack1, done0, done1, busy;
  logic [7:0] y;

  // W=2 instance for the exhaustive sweep
  logic       p_req0, p_req1;
  logic [1:0] p_a0, p_b0, p_a1, p_b1;
  logic       p_ack0, p_ack1, p_done0, p_done1, p_busy;
  logic [1:0] p_y;

  nand_xor_sched #(.W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .y(y), .busy(busy)
  );

  nand_xor_sched #(.W(2)) dut2 (
    .clk(clk), .rst(rst),
    .req0(p_req0), .a0(p_a0), .b0(p_b0),
    .req1(p_req1), .a1(p_a1), .b1(p_b1),
    .ack0(p_ack0), .ack1(p_ack1), .done0(p_done0), .done1(p_done1),
    .y(p_y), .busy(p_busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         r;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    p_req0 = 1'b0; p_req1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One operation on the W=8 instance: request, wait for ack (bounded),
  // drop req, then check the DONE cycle lands 5 cycles after ack.
  task automatic op8(input bit r, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp_y, input string nm);
    bit got;
    got = 1'b0;
    if (r) begin req1 = 1'b1; a1 = a; b1 = b; end
    else   begin req0 = 1'b1; a0 = a; b0 = b; end
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if ((r ? ack1 : ack0) === 1'b1) got = 1'b1;
    end
    chk({nm, " ack"}, 32'(got), 32'd1);
    if (r) req1 = 1'b0; else req0 = 1'b0;
    if (!got) return;
    chk({nm, " other_ack"}, 32'(r ? ack0 : ack1), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("%s done c%0d", nm, c), 32'(r ? done1 : done0), 32'(c == 5));
      chk($sformatf("%s other_done c%0d", nm, c), 32'(r ? done0 : done1), 32'd0);
      chk($sformatf("%s y c%0d", nm, c), 32'(y), (c == 5) ? 32'(exp_y) : 32'd0);
    end
    tick();
    $display("op %s req%0d a=%02h b=%02h y_exp=%02h", nm, r, a, b, exp_y);
    chk({nm, " busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 8'h0F, 8'hAA};
    vecs[1] = '{1'b1, 8'h55, 8'hAA, 8'hFF};
    vecs[2] = '{1'b0, 8'hFF, 8'hFF, 8'h00};
    vecs[3] = '{1'b1, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{1'b0, 8'h12, 8'h34, 8'h26};
    vecs[5] = '{1'b1, 8'hF0, 8'h0F, 8'hFF};

    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    p_a0 = '0; p_b0 = '0; p_a1 = '0; p_b1 = '0;

    // Reset state, observed while rst is still asserted
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; p_req0 = 1'b0; p_req1 = 1'b0;
    tick(); tick();
    chk("rst ack0", 32'(ack0), 32'd0);
    chk("rst ack1", 32'(ack1), 32'd0);
    chk("rst done0", 32'(done0), 32'd0);
    chk("rst done1", 32'(done1), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst y", 32'(y), 32'd0);
    rst = 1'b0;

    // Table-driven single operations
    for (int i = 0; i < 6; i++)
      op8(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp_y, $sformatf("vec%0d", i));

    // Simultaneous requests right after reset: req0 first, req1 7 cycles later
    do_reset();
    req0 = 1'b1; a0 = 8'hFF; b0 = 8'h00;
    req1 = 1'b1; a1 = 8'h3C; b1 = 8'h3C;
    for (int c = 0; c <= 12; c++) begin
      tick();
      chk($sformatf("tie ack0 c%0d", c), 32'(ack0), 32'(c == 0));
      chk($sformatf("tie ack1 c%0d", c), 32'(ack1), 32'(c == 7));
      chk($sformatf("tie done0 c%0d", c), 32'(done0), 32'(c == 5));
      chk($sformatf("tie done1 c%0d", c), 32'(done1), 32'(c == 12));
      chk($sformatf("tie y c%0d", c), 32'(y), (c == 5) ? 32'hFF : 32'd0);
      chk($sformatf("tie busy c%0d", c), 32'(busy), 32'(c != 6));
      if (c == 0) req0 = 1'b0;
      if (c == 7) req1 = 1'b0;
    end
    $display("op tie: req0 then req1, y=ff then y=00");

    // Both held for four operations: acks alternate 0,1,0,1
    do_reset();
    req0 = 1'b1; a0 = 8'h0F; b0 = 8'hF0;
    req1 = 1'b1; a1 = 8'h11; b1 = 8'h22;
    for (int c = 0; c <= 27; c++) begin
      tick();
      chk($sformatf("rr ack0 c%0d", c), 32'(ack0), 32'(c == 0 || c == 14));
      chk($sformatf("rr ack1 c%0d", c), 32'(ack1), 32'(c == 7 || c == 21));
      chk($sformatf("rr busy c%0d", c), 32'(busy), 32'((c % 7) != 6));
      if (c == 21) begin req0 = 1'b0; req1 = 1'b0; end
    end
    $display("op round-robin: four grants 0,1,0,1");

    // Reset during S3 aborts the operation
    do_reset();
    req0 = 1'b1; a0 = 8'hC3; b0 = 8'h3C;
    for (int c = 0; c <= 2; c++) begin
      tick();
      if (c == 0) begin
        chk("abort ack0", 32'(ack0), 32'd1);
        req0 = 1'b0;
      end
    end
    rst = 1'b1;  // now in S3
    tick();
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ack0", 32'(ack0), 32'd0);
    chk("abort done0", 32'(done0), 32'd0);
    chk("abort y", 32'(y), 32'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("abort nodone c%0d", c), 32'(done0 | done1), 32'd0);
    end
    $display("op abort: reset in S3, no done");
    op8(1'b1, 8'h55, 8'hAA, 8'hFF, "post_abort");

    // req0 dropped in S2: operation completes, no second ack
    do_reset();
    req0 = 1'b1; a0 = 8'h3C; b0 = 8'hC3;
    for (int c = 0; c <= 12; c++) begin
      tick();
      chk($sformatf("drop ack0 c%0d", c), 32'(ack0), 32'(c == 0));
      chk($sformatf("drop done0 c%0d", c), 32'(done0), 32'(c == 5));
      chk($sformatf("drop y c%0d", c), 32'(y), (c == 5) ? 32'hFF : 32'd0);
      if (c == 1) req0 = 1'b0;
    end
    $display("op drop: req0 dropped in S2, done0 still pulsed");

    // Exhaustive W=2 sweep on requester 1
    do_reset();
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        logic [1:0] ea;
        bit got;
        ea = 2'(a) ^ 2'(b);
        got = 1'b0;
        p_req1 = 1'b1; p_a1 = 2'(a); p_b1 = 2'(b);
        for (int i = 0; i < 20 && !got; i++) begin
          tick();
          if (p_ack1 === 1'b1) got = 1'b1;
          else chk($sformatf("w2 y_wait a%0d b%0d", a, b), 32'(p_y), 32'd0);
        end
        p_req1 = 1'b0;
        chk($sformatf("w2 ack a%0d b%0d", a, b), 32'(got), 32'd1);
        chk($sformatf("w2 y_ack a%0d b%0d", a, b), 32'(p_y), 32'd0);
        for (int c = 1; c <= 6; c++) begin
          tick();
          chk($sformatf("w2 done1 a%0d b%0d c%0d", a, b, c), 32'(p_done1), 32'(c == 5));
          chk($sformatf("w2 y a%0d b%0d c%0d", a, b, c), 32'(p_y),
              (c == 5) ? 32'(ea) : 32'd0);
        end
        $display("op w2 a=%0d b=%0d y_exp=%0d", a, b, ea);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
